// File: rtl/aurva_pass_scheduler_if.sv
// Purpose: groups the job-control, master-handshake and status signals of the pass scheduler.
// Latency: none, wiring only.
// Backpressure: none; start/done are single-cycle pulses with no ready path.
interface aurva_pass_scheduler_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_PASS_CNT_WIDTH   = 8
);
  logic                          ap_start;
  logic                          ap_done;
  logic                          ap_idle;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_src_addr;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_dst_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes;
  logic [C_PASS_CNT_WIDTH-1:0]   ctrl_num_passes;
  logic                          ctrl_is_intt;
  logic                          rd_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_offset;
  logic                          rd_done;
  logic                          wr_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset;
  logic                          wr_done;
  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size;
  logic                          kernel_is_intt;
  logic [C_PASS_CNT_WIDTH-1:0]   pass_index;
  logic [C_M_AXI_ADDR_WIDTH-1:0] final_addr;
  logic                          cfg_err;
  logic [31:0]                   perf_cycles;

  // Scheduler side.
  modport master (
    input  ap_start, ctrl_src_addr, ctrl_dst_addr, ctrl_xfer_size_in_bytes,
           ctrl_num_passes, ctrl_is_intt, rd_done, wr_done,
    output ap_done, ap_idle, rd_start, rd_addr_offset, wr_start, wr_addr_offset,
           xfer_size, kernel_is_intt, pass_index, final_addr, cfg_err, perf_cycles
  );

  // Host / memory-master side.
  modport slave (
    output ap_start, ctrl_src_addr, ctrl_dst_addr, ctrl_xfer_size_in_bytes,
           ctrl_num_passes, ctrl_is_intt, rd_done, wr_done,
    input  ap_done, ap_idle, rd_start, rd_addr_offset, wr_start, wr_addr_offset,
           xfer_size, kernel_is_intt, pass_index, final_addr, cfg_err, perf_cycles
  );
endinterface

// File: rtl/aurva_pass_scheduler.sv
// Purpose: sequences multi-pass ping-pong transform jobs between buffers A and B.
// Latency: start->rd/wr_start 1 cycle; done pair->next launch 2 cycles; final done pair->ap_done 1 cycle.
// Backpressure: none; waits for both master done pulses, stray or duplicate pulses are absorbed.
module aurva_pass_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_PASS_CNT_WIDTH   = 8
) (
  input logic                    aclk,
  input logic                    areset,
  aurva_pass_scheduler_if.master bus
);

  localparam logic [C_PASS_CNT_WIDTH-1:0] PASS_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched job configuration.
  logic [C_M_AXI_ADDR_WIDTH-1:0] src_q, dst_q;
  logic [C_PASS_CNT_WIDTH-1:0]   num_passes_q;

  // Pass bookkeeping.
  logic [C_PASS_CNT_WIDTH-1:0]   pass_index_q, pass_index_d;
  logic                          rd_seen_q, rd_seen_d;
  logic                          wr_seen_q, wr_seen_d;

  // Registered outputs.
  logic                          ap_done_q, ap_idle_q;
  logic                          rd_start_q, wr_start_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q, final_addr_q;
  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_q;
  logic                          kernel_is_intt_q;
  logic                          cfg_err_q;
  logic [31:0]                   perf_q;

  // Decode helpers.
  logic                          start_accept;
  logic                          cfg_bad;
  logic                          last_pass;
  logic [C_M_AXI_ADDR_WIDTH-1:0] src_eff, dst_eff;

  assign cfg_bad   = (bus.ctrl_num_passes == '0) || (bus.ctrl_xfer_size_in_bytes == '0);
  assign last_pass = (pass_index_q == (num_passes_q - PASS_ONE));
  // On the accepting cycle the config registers are not loaded yet, so use the live inputs.
  assign src_eff   = start_accept ? bus.ctrl_src_addr : src_q;
  assign dst_eff   = start_accept ? bus.ctrl_dst_addr : dst_q;

  // Next-state, pass counter and done-flag tracking.
  always_comb begin
    state_d      = state_q;
    pass_index_d = pass_index_q;
    rd_seen_d    = rd_seen_q;
    wr_seen_d    = wr_seen_q;
    start_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          start_accept = 1'b1;
          pass_index_d = '0;
          rd_seen_d    = 1'b0;
          wr_seen_d    = 1'b0;
          state_d      = cfg_bad ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        // Flags are sticky so the two masters may finish in any order.
        rd_seen_d = rd_seen_q | bus.rd_done;
        wr_seen_d = wr_seen_q | bus.wr_done;
        if (rd_seen_d && wr_seen_d) begin
          state_d = last_pass ? S_DONE : S_NEXT;
        end
      end
      S_NEXT: begin
        pass_index_d = pass_index_q + PASS_ONE;
        state_d      = S_LAUNCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Config latch, pass bookkeeping and registered outputs derived from the next state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      src_q            <= '0;
      dst_q            <= '0;
      num_passes_q     <= '0;
      pass_index_q     <= '0;
      rd_seen_q        <= 1'b0;
      wr_seen_q        <= 1'b0;
      ap_done_q        <= 1'b0;
      ap_idle_q        <= 1'b1;
      rd_start_q       <= 1'b0;
      wr_start_q       <= 1'b0;
      rd_addr_q        <= '0;
      wr_addr_q        <= '0;
      final_addr_q     <= '0;
      xfer_size_q      <= '0;
      kernel_is_intt_q <= 1'b0;
      cfg_err_q        <= 1'b0;
      perf_q           <= '0;
    end else begin
      pass_index_q <= pass_index_d;
      rd_seen_q    <= rd_seen_d;
      wr_seen_q    <= wr_seen_d;

      if (start_accept) begin
        src_q            <= bus.ctrl_src_addr;
        dst_q            <= bus.ctrl_dst_addr;
        num_passes_q     <= bus.ctrl_num_passes;
        xfer_size_q      <= bus.ctrl_xfer_size_in_bytes;
        kernel_is_intt_q <= bus.ctrl_is_intt;
        cfg_err_q        <= cfg_bad;
        perf_q           <= '0;
      end else if (state_q != S_IDLE && perf_q != '1) begin
        perf_q <= perf_q + 32'd1;
      end

      rd_start_q <= (state_d == S_LAUNCH);
      wr_start_q <= (state_d == S_LAUNCH);
      ap_done_q  <= (state_d == S_DONE);
      ap_idle_q  <= (state_d == S_IDLE);

      // Even passes read A and write B; odd passes swap the roles.
      if (state_d == S_LAUNCH) begin
        rd_addr_q <= pass_index_d[0] ? dst_eff : src_eff;
        wr_addr_q <= pass_index_d[0] ? src_eff : dst_eff;
      end

      // The result lives wherever the last pass wrote; a rejected job points at A.
      if (start_accept && cfg_bad) begin
        final_addr_q <= bus.ctrl_src_addr;
      end else if (state_q == S_RUN && state_d == S_DONE) begin
        final_addr_q <= wr_addr_q;
      end
    end
  end

  assign bus.ap_done        = ap_done_q;
  assign bus.ap_idle        = ap_idle_q;
  assign bus.rd_start       = rd_start_q;
  assign bus.wr_start       = wr_start_q;
  assign bus.rd_addr_offset = rd_addr_q;
  assign bus.wr_addr_offset = wr_addr_q;
  assign bus.xfer_size      = xfer_size_q;
  assign bus.kernel_is_intt = kernel_is_intt_q;
  assign bus.pass_index     = pass_index_q;
  assign bus.final_addr     = final_addr_q;
  assign bus.cfg_err        = cfg_err_q;
  assign bus.perf_cycles    = perf_q;

endmodule

// File: tb/tb_aurva_pass_scheduler.sv
// Purpose: directed self-checking bench for the pass scheduler.
// Latency: checks exact cycle placement of start, next-pass and done pulses.
// Backpressure: drives done pulses in both orders, together, duplicated and stray.
module tb_aurva_pass_scheduler;

  logic aclk;
  logic areset;
  int   total;
  int   bad;
  int   rd_cnt;
  int   wr_cnt;
  int   done_cnt;

  aurva_pass_scheduler_if #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_XFER_SIZE_WIDTH (32),
    .C_PASS_CNT_WIDTH  (8)
  ) bus ();

  aurva_pass_scheduler #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_XFER_SIZE_WIDTH (32),
    .C_PASS_CNT_WIDTH  (8)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Pulse counters sampled mid-cycle.
  always @(negedge aclk) begin
    if (bus.rd_start) rd_cnt++;
    if (bus.wr_start) wr_cnt++;
    if (bus.ap_done)  done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive done pulses for one cycle, ending one cycle later.
  task automatic pulse(input logic rd, input logic wr);
    bus.rd_done = rd;
    bus.wr_done = wr;
    tick();
    bus.rd_done = 1'b0;
    bus.wr_done = 1'b0;
  endtask

  task automatic setup(input logic [63:0] src, input logic [63:0] dst,
                       input logic [31:0] size, input logic [7:0] passes, input logic intt);
    bus.ctrl_src_addr           = src;
    bus.ctrl_dst_addr           = dst;
    bus.ctrl_xfer_size_in_bytes = size;
    bus.ctrl_num_passes         = passes;
    bus.ctrl_is_intt            = intt;
  endtask

  initial begin
    int rd0;
    int wr0;
    int dn0;
    total    = 0;
    bad      = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    areset   = 1'b1;
    bus.ap_start = 1'b0;
    bus.rd_done  = 1'b0;
    bus.wr_done  = 1'b0;
    setup(64'h0, 64'h0, 32'd0, 8'd0, 1'b0);

    // Reset state.
    tick();
    tick();
    check("rst_idle",  64'(bus.ap_idle), 64'd1);
    check("rst_done",  64'(bus.ap_done), 64'd0);
    check("rst_rdst",  64'(bus.rd_start), 64'd0);
    check("rst_pass",  64'(bus.pass_index), 64'd0);
    check("rst_perf",  64'(bus.perf_cycles), 64'd0);
    check("rst_final", bus.final_addr, 64'd0);
    check("rst_cfg",   64'(bus.cfg_err), 64'd0);
    areset = 1'b0;
    tick();

    // Single pass, wr_done then rd_done.
    setup(64'h1000, 64'h8000, 32'd4096, 8'd1, 1'b1);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check("s1_rdst",  64'(bus.rd_start), 64'd1);
    check("s1_wrst",  64'(bus.wr_start), 64'd1);
    check("s1_rdadr", bus.rd_addr_offset, 64'h1000);
    check("s1_wradr", bus.wr_addr_offset, 64'h8000);
    check("s1_idle",  64'(bus.ap_idle), 64'd0);
    check("s1_size",  64'(bus.xfer_size), 64'd4096);
    check("s1_intt",  64'(bus.kernel_is_intt), 64'd1);
    tick();
    check("s1_rdst_lo", 64'(bus.rd_start), 64'd0);
    pulse(1'b0, 1'b1);
    check("s1_early", 64'(bus.ap_done), 64'd0);
    pulse(1'b1, 1'b0);
    check("s1_done",  64'(bus.ap_done), 64'd1);
    check("s1_final", bus.final_addr, 64'h8000);
    tick();
    check("s1_done_lo", 64'(bus.ap_done), 64'd0);
    check("s1_idle2",   64'(bus.ap_idle), 64'd1);
    check("s1_perf",    64'(bus.perf_cycles), 64'd4);
    check("s1_nstart",  64'(rd_cnt), 64'd1);

    // Three passes, wr_done before rd_done each pass.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    setup(64'h1000, 64'h8000, 32'd256, 8'd3, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      check("m3_rdst",  64'(bus.rd_start), 64'd1);
      check("m3_rdadr", bus.rd_addr_offset, (p % 2 == 1) ? 64'h8000 : 64'h1000);
      check("m3_wradr", bus.wr_addr_offset, (p % 2 == 1) ? 64'h1000 : 64'h8000);
      check("m3_pass",  64'(bus.pass_index), 64'(p));
      tick();
      pulse(1'b0, 1'b1);
      check("m3_wait",  64'(bus.ap_done), 64'd0);
      pulse(1'b1, 1'b0);
      if (p < 2) begin
        check("m3_next_nodone", 64'(bus.ap_done), 64'd0);
        check("m3_next_nostart", 64'(bus.rd_start), 64'd0);
        tick();
      end
    end
    check("m3_done",   64'(bus.ap_done), 64'd1);
    check("m3_final",  bus.final_addr, 64'h8000);
    check("m3_intt",   64'(bus.kernel_is_intt), 64'd0);
    check("m3_size",   64'(bus.xfer_size), 64'd256);
    check("m3_nrd",    64'(rd_cnt - rd0), 64'd3);
    check("m3_nwr",    64'(wr_cnt - wr0), 64'd3);
    tick();

    // Two passes, both dones in the same cycle.
    setup(64'h1000, 64'h8000, 32'd128, 8'd2, 1'b1);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    pulse(1'b1, 1'b1);
    check("sc_next_rdst", 64'(bus.rd_start), 64'd0);
    check("sc_next_done", 64'(bus.ap_done), 64'd0);
    tick();
    check("sc_launch",  64'(bus.rd_start), 64'd1);
    check("sc_rdadr",   bus.rd_addr_offset, 64'h8000);
    check("sc_wradr",   bus.wr_addr_offset, 64'h1000);
    check("sc_pass",    64'(bus.pass_index), 64'd1);
    tick();
    pulse(1'b1, 1'b1);
    check("sc_done",    64'(bus.ap_done), 64'd1);
    check("sc_final",   bus.final_addr, 64'h1000);
    tick();

    // Illegal configurations: zero passes, then zero size.
    rd0 = rd_cnt;
    setup(64'h1000, 64'h8000, 32'd4096, 8'd0, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check("ce0_done",  64'(bus.ap_done), 64'd1);
    check("ce0_err",   64'(bus.cfg_err), 64'd1);
    check("ce0_final", bus.final_addr, 64'h1000);
    tick();
    check("ce0_sticky", 64'(bus.cfg_err), 64'd1);
    check("ce0_perf",   64'(bus.perf_cycles), 64'd1);
    setup(64'h2000, 64'h8000, 32'd0, 8'd1, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check("ce1_done",  64'(bus.ap_done), 64'd1);
    check("ce1_err",   64'(bus.cfg_err), 64'd1);
    check("ce1_final", bus.final_addr, 64'h2000);
    tick();
    check("ce_nstart", 64'(rd_cnt - rd0), 64'd0);

    // Legal job clears cfg_err; ap_start held through DONE restarts after one IDLE cycle.
    setup(64'h1000, 64'h8000, 32'd64, 8'd1, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check("ce_clr", 64'(bus.cfg_err), 64'd0);
    tick();
    pulse(1'b1, 1'b1);
    check("hs_done", 64'(bus.ap_done), 64'd1);
    bus.ap_start = 1'b1;
    tick();
    check("hs_idle",  64'(bus.ap_idle), 64'd1);
    check("hs_norst", 64'(bus.rd_start), 64'd0);
    tick();
    bus.ap_start = 1'b0;
    check("hs_relaunch", 64'(bus.rd_start), 64'd1);
    tick();
    pulse(1'b1, 1'b1);
    tick();

    // Reset during pass 1 of a 4-pass job.
    setup(64'h1000, 64'h8000, 32'd512, 8'd4, 1'b1);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    pulse(1'b1, 1'b1);
    tick();
    tick();
    check("ar_pass1", 64'(bus.pass_index), 64'd1);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("ar_idle",  64'(bus.ap_idle), 64'd1);
    check("ar_pass0", 64'(bus.pass_index), 64'd0);
    check("ar_intt",  64'(bus.kernel_is_intt), 64'd0);
    pulse(1'b1, 1'b0);
    tick();
    check("ar_still_idle", 64'(bus.ap_idle), 64'd1);
    check("ar_nodone",     64'(done_cnt - dn0), 64'd0);
    check("ar_nostart",    64'(rd_cnt - rd0), 64'd0);
    setup(64'h1000, 64'h8000, 32'd4096, 8'd1, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check("ar_new_rdadr", bus.rd_addr_offset, 64'h1000);
    tick();
    pulse(1'b1, 1'b1);
    check("ar_new_done",  64'(bus.ap_done), 64'd1);
    check("ar_new_final", bus.final_addr, 64'h8000);
    tick();

    // Stray rd_done in IDLE, duplicate wr_done in RUN.
    pulse(1'b1, 1'b0);
    check("st_idle", 64'(bus.ap_idle), 64'd1);
    check("st_perf", 64'(bus.perf_cycles), 64'd3);
    setup(64'h1000, 64'h8000, 32'd4096, 8'd1, 1'b0);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("dup_nodone", 64'(bus.ap_done), 64'd0);
    tick();
    check("dup_nodone2", 64'(bus.ap_done), 64'd0);
    pulse(1'b1, 1'b0);
    check("dup_done", 64'(bus.ap_done), 64'd1);
    tick();
    check("dup_perf", 64'(bus.perf_cycles), 64'd6);
    tick();
    check("dup_perf_hold", 64'(bus.perf_cycles), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aurva_pass_scheduler.md
AURVA_PASS_SCHEDULER -- requirements
Module: aurva_pass_scheduler

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, width of all address ports.
REQ-002 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, width of transfer-size ports.
REQ-003 SHALL have parameter C_PASS_CNT_WIDTH, default 8, width of pass count and index.
REQ-004 SHALL use one clock and synchronous, active-high reset: aclk  in  1  clock; areset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports:
- ap_start  in  1  job request, level, sampled only in IDLE
- ap_done  out  1  one-cycle job-complete pulse
- ap_idle  out  1  high in IDLE
- ctrl_src_addr  in  C_M_AXI_ADDR_WIDTH  buffer A base
- ctrl_dst_addr  in  C_M_AXI_ADDR_WIDTH  buffer B base
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  bytes per pass
- ctrl_num_passes  in  C_PASS_CNT_WIDTH  passes per job
- ctrl_is_intt  in  1  transform direction for the job
- rd_start  out  1  read-master start pulse
- rd_addr_offset  out  C_M_AXI_ADDR_WIDTH  read base for the current pass
- rd_done  in  1  read-master done pulse
- wr_start  out  1  write-master start pulse
- wr_addr_offset  out  C_M_AXI_ADDR_WIDTH  write base for the current pass
- wr_done  in  1  write-master done pulse
- xfer_size  out  C_XFER_SIZE_WIDTH  latched byte count driven to both masters
- kernel_is_intt  out  1  latched direction driven to the transform datapath
- pass_index  out  C_PASS_CNT_WIDTH  current pass, 0-based
- final_addr  out  C_M_AXI_ADDR_WIDTH  base holding the job result, valid from ap_done
- cfg_err  out  1  sticky illegal-config flag
- perf_cycles  out  32  job cycle count

Function
REQ-006 SHALL implement states IDLE, LAUNCH, RUN, NEXT, DONE. All outputs SHALL be registered.
REQ-007 In IDLE with ap_start=1: latch src, dst, size, num_passes and is_intt; clear pass_index, perf_cycles and cfg_err. If num_passes=0 or size=0: set cfg_err and go to DONE with no rd_start or wr_start. Otherwise go to LAUNCH.
REQ-008 LAUNCH SHALL last exactly 1 cycle, with rd_start=wr_start=1 and both done-seen flags cleared, then go to RUN.
REQ-009 Even pass_index SHALL read src and write dst; odd pass_index SHALL read dst and write src (ping-pong). Offsets SHALL be stable from LAUNCH until the next LAUNCH or IDLE.
REQ-010 RUN SHALL capture rd_done and wr_done into sticky flags, in either order or the same cycle. When both flags are set (including the cycle a pulse arrives): go to DONE if pass_index=num_passes-1, else go to NEXT.
REQ-011 NEXT SHALL last 1 cycle, increment pass_index, then go to LAUNCH. Pass-to-pass gap: last done at cycle D, then LAUNCH at D+2.
REQ-012 Latency: start sampled at cycle T, then rd_start/wr_start high at T+1. Final done pair at cycle D, then ap_done high at D+1.
REQ-013 DONE SHALL last 1 cycle, with ap_done=1 and final_addr = last pass's write base (dst if num_passes odd, else src); then go to IDLE. On an illegal config, final_addr = src.
REQ-014 ap_start held high through DONE SHALL start a new job in the following IDLE cycle. ap_start outside IDLE SHALL be ignored.
REQ-015 rd_done/wr_done outside RUN SHALL be ignored. Duplicate done pulses within one pass SHALL have no extra effect.
REQ-016 perf_cycles SHALL increment every cycle outside IDLE, saturate at 2^32-1, and hold after DONE until the next accepted start.
REQ-017 cfg_err SHALL remain set until the next accepted start.
REQ-018 kernel_is_intt and xfer_size SHALL stay constant for the whole job.

Reset
REQ-019 With areset=1 at a clock edge, the next state SHALL be IDLE. All outputs SHALL be 0 except ap_idle=1; internal flags and counters SHALL be 0.
REQ-020 Reset mid-job SHALL abort with no ap_done and no further start pulses. Done pulses arriving after reset SHALL be ignored.

Verification
REQ-021 Single pass (src=0x1000, dst=0x8000, size=4096, passes=1) -> one rd/wr_start pair with rd_addr=0x1000, wr_addr=0x8000; ap_done 1 cycle after the later done; final_addr=0x8000.
REQ-022 Three passes, wr_done before rd_done each pass -> offsets (0x1000→0x8000), (0x8000→0x1000), (0x1000→0x8000); pass_index 0,1,2; exactly 3 start pairs; final_addr=0x8000.
REQ-023 rd_done and wr_done in the same cycle at D -> NEXT at D+1, LAUNCH at D+2; two passes -> final_addr=0x1000.
REQ-024 passes=0 or size=0 -> cfg_err=1, ap_done at T+1, no start pulses; next legal start clears cfg_err.
REQ-025 areset asserted in RUN of pass 1 of 4 -> ap_idle=1, pass_index=0, no ap_done; a later rd_done is ignored; a new job runs normally.
REQ-026 Stray rd_done in IDLE and a duplicate wr_done in RUN -> no state change and no early completion; perf_cycles equals the cycles from leaving IDLE through DONE.
